// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the microsequencer slice:
// FSM state encodings and parameter defaults.
package fetch_sequencer_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int VOID_SLOTS_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/program_counter.sv
// Microprogram counter: ADDR_W register with load (priority) and +1 wrap.
// Ports: clk, reset (async high), load, load_val, inc -> pc.
module program_counter #(
  parameter int ADDR_W       = 10,
  parameter int RESET_VECTOR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= ADDR_W'(RESET_VECTOR);
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      // Natural wrap at 2^ADDR_W.
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Microsequencer: drives ROM fetch, IR load and IR void (NOP) line.
// Ports: clk, reset, run, stall, halt_req, branch_taken, branch_target
//   -> rom_addr, rom_en, ir_load, is_void, halted.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int VOID_SLOTS   = VOID_SLOTS_DEF,
  parameter int RESET_VECTOR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  output logic              ir_load,
  output logic              is_void,
  output logic              halted
);

  localparam logic [1:0] VOID_INIT = 2'(VOID_SLOTS);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  void_cnt;
  logic [1:0]  void_nxt;
  logic        pc_load;
  logic        pc_inc;
  logic [ADDR_W-1:0] pc;

  program_counter #(
    .ADDR_W       (ADDR_W),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .load_val (branch_target),
    .inc      (pc_inc),
    .pc       (pc)
  );

  assign rom_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      void_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      void_cnt <= void_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    void_nxt  = void_cnt;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    rom_en    = 1'b0;
    ir_load   = 1'b0;
    is_void   = 1'b1;
    halted    = 1'b0;
    unique case (state)
      ST_IDLE, ST_HALT: begin
        halted = (state == ST_HALT);
        if (run) begin
          state_nxt = ST_RUN;
          void_nxt  = VOID_INIT;
        end
      end
      ST_RUN: begin
        is_void = (void_cnt != 2'd0);
        if (!stall) begin
          rom_en  = 1'b1;
          ir_load = 1'b1;
          // A voided slot is a NOP, so it cannot branch.
          if (branch_taken && void_cnt == 2'd0) begin
            pc_load  = 1'b1;
            void_nxt = VOID_INIT;
          end else begin
            pc_inc = 1'b1;
            if (void_cnt != 2'd0)
              void_nxt = void_cnt - 2'd1;
          end
          if (halt_req)
            state_nxt = ST_HALT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: driver queues per-cycle
// expectations, monitor pops and compares on the falling edge.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       stall = 1'b0;
  logic       halt_req = 1'b0;
  logic       branch_taken = 1'b0;
  logic [9:0] branch_target = '0;
  logic [9:0] rom_addr;
  logic       rom_en;
  logic       ir_load;
  logic       is_void;
  logic       halted;

  typedef struct {
    int         cyc;
    int         idx;
    logic [9:0] addr;
    logic       vd;
    logic       en;
    logic       hl;
  } exp_t;

  exp_t q[$];
  int   cycnt = 0;
  int   vidx = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .stall         (stall),
    .halt_req      (halt_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .rom_addr      (rom_addr),
    .rom_en        (rom_en),
    .ir_load       (ir_load),
    .is_void       (is_void),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycnt <= cycnt + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cycnt) begin
      exp_t s;
      s = q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL vec%0d stale: never compared", s.idx);
    end
    if (q.size() > 0 && q[0].cyc == cycnt) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (rom_addr !== e.addr || is_void !== e.vd ||
          rom_en !== e.en || ir_load !== e.en ||
          halted !== e.hl) begin
        n_bad++;
        $display({"FAIL vec%0d: got addr=%h void=%b en=%b ",
                  "ld=%b halt=%b, want addr=%h void=%b ",
                  "en=%b ld=%b halt=%b"},
                 e.idx, rom_addr, is_void, rom_en, ir_load,
                 halted, e.addr, e.vd, e.en, e.en, e.hl);
      end
    end
  end

  task automatic step(
    input logic       r,
    input logic       s,
    input logic       h,
    input logic       b,
    input logic [9:0] t,
    input logic       rs,
    input logic [9:0] ea,
    input logic       ev,
    input logic       een,
    input logic       ehl
  );
    exp_t e;
    reset         = rs;
    run           = r;
    stall         = s;
    halt_req      = h;
    branch_taken  = b;
    branch_target = t;
    e.cyc  = cycnt;
    e.idx  = vidx;
    e.addr = ea;
    e.vd   = ev;
    e.en   = een;
    e.hl   = ehl;
    q.push_back(e);
    vidx++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset state
    step(0,0,0,0,10'h000,1, 10'h000,1,0,0);
    step(0,0,0,0,10'h000,0, 10'h000,1,0,0);
    // start: two void slots, then straight-line
    step(1,0,0,0,10'h000,0, 10'h000,1,0,0);
    step(0,0,0,0,10'h000,0, 10'h000,1,1,0);
    step(0,0,0,0,10'h000,0, 10'h001,1,1,0);
    step(0,0,0,0,10'h000,0, 10'h002,0,1,0);
    step(0,0,0,0,10'h000,0, 10'h003,0,1,0);
    step(0,0,0,0,10'h000,0, 10'h004,0,1,0);
    step(0,0,0,0,10'h000,0, 10'h005,0,1,0);
    step(0,0,0,0,10'h000,0, 10'h006,0,1,0);
    // taken branch at 0x007; branch in void slot ignored
    step(0,0,0,1,10'h040,0, 10'h007,0,1,0);
    step(0,0,0,1,10'h200,0, 10'h040,1,1,0);
    step(0,0,0,0,10'h000,0, 10'h041,1,1,0);
    step(0,0,0,0,10'h000,0, 10'h042,0,1,0);
    // stall with one void pending; halt/branch ignored
    step(0,0,0,1,10'h080,0, 10'h043,0,1,0);
    step(0,0,0,0,10'h000,0, 10'h080,1,1,0);
    step(0,1,0,0,10'h000,0, 10'h081,1,0,0);
    step(0,1,1,1,10'h300,0, 10'h081,1,0,0);
    step(0,1,0,0,10'h000,0, 10'h081,1,0,0);
    step(0,0,0,0,10'h000,0, 10'h081,1,1,0);
    step(0,0,0,0,10'h000,0, 10'h082,0,1,0);
    // wrap 0x3FF -> 0x000
    step(0,0,0,1,10'h3FC,0, 10'h083,0,1,0);
    step(0,0,0,0,10'h000,0, 10'h3FC,1,1,0);
    step(0,0,0,0,10'h000,0, 10'h3FD,1,1,0);
    step(0,0,0,0,10'h000,0, 10'h3FE,0,1,0);
    step(0,0,0,0,10'h000,0, 10'h3FF,0,1,0);
    step(0,0,0,0,10'h000,0, 10'h000,0,1,0);
    step(0,0,0,0,10'h000,0, 10'h001,0,1,0);
    // halt + branch same cycle
    step(0,0,1,1,10'h100,0, 10'h002,0,1,0);
    step(0,0,0,0,10'h000,0, 10'h100,1,0,1);
    step(0,0,0,1,10'h155,0, 10'h100,1,0,1);
    step(1,0,0,0,10'h000,0, 10'h100,1,0,1);
    step(0,0,0,0,10'h000,0, 10'h100,1,1,0);
    step(1,0,0,0,10'h000,0, 10'h101,1,1,0);
    step(0,0,0,0,10'h000,0, 10'h102,0,1,0);
    // plain halt still fetches its cycle
    step(0,0,1,0,10'h000,0, 10'h103,0,1,0);
    step(0,0,0,0,10'h000,0, 10'h104,1,0,1);
    step(1,0,0,0,10'h000,0, 10'h104,1,0,1);
    step(0,0,0,0,10'h000,0, 10'h104,1,1,0);
    // async reset between edges
    step(0,0,0,0,10'h000,1, 10'h000,1,0,0);
    step(0,0,0,0,10'h000,0, 10'h000,1,0,0);
    repeat (2) @(posedge clk);
    #1;
    while (q.size() > 0) begin
      exp_t s;
      s = q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL vec%0d unchecked: monitor never ran", s.idx);
    end
    run = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_vec++;
    if (rom_addr !== 10'h000) begin
      n_bad++;
      $display("FAIL mid-reset: rom_addr=%h", rom_addr);
    end
    if (is_void !== 1'b1) begin
      n_bad++;
      $display("FAIL mid-reset: is_void=%b", is_void);
    end
    if (ir_load !== 1'b0) begin
      n_bad++;
      $display("FAIL mid-reset: ir_load=%b", ir_load);
    end
    if (halted !== 1'b0) begin
      n_bad++;
      $display("FAIL mid-reset: halted=%b", halted);
    end
    if (rom_en !== 1'b0) begin
      n_bad++;
      $display("FAIL mid-reset: rom_en=%b", rom_en);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    if (n_bad != 0)
      $display("TEST FAILED");
    else
      $display("TEST PASSED");
    $finish;
  end

endmodule
